// File: rtl/dac_spi_tx.sv
// MCP4911 write-frame serialiser: packs a 10-bit offset-binary code into a
// 16-bit frame, shifts it MSB-first, then strobes LDAC. One-deep pending buffer.
module dac_spi_tx #(
  parameter int CLK_DIV = 25
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic [9:0] data_in,
  input  logic       load,
  output logic       busy,
  output logic       overrun,
  output logic       dac_sdi,
  output logic       dac_sck,
  output logic       dac_cs_n,
  output logic       dac_ld_n
);

  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_CSUP  = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    half_q, half_d;
  logic [15:0]   shreg_q, shreg_d;
  logic [9:0]    pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic          sdi_q, sdi_d;
  logic          sck_q, sck_d;
  logic          cs_n_q, cs_n_d;
  logic          ld_n_q, ld_n_d;
  logic          busy_q, busy_d;
  logic          ovr_q, ovr_d;

  logic          tick;
  logic          latch_end;
  logic          start;
  logic          to_pending;
  logic [9:0]    start_data;
  logic [15:0]   start_frame;

  assign tick        = (div_q == DIV_LAST);
  assign latch_end   = (state_q == S_LATCH) && tick;
  assign start_frame = {4'b0011, start_data, 2'b00};

  // A frame starts from IDLE on load, or back-to-back as LATCH ends: the
  // pending sample has priority, otherwise a same-edge load acts as in IDLE.
  always_comb begin
    start      = 1'b0;
    start_data = data_in;
    if (state_q == S_IDLE) begin
      start = load;
    end else if (latch_end) begin
      if (pend_vld_q) begin
        start      = 1'b1;
        start_data = pend_q;
      end else begin
        start = load;
      end
    end
  end

  assign to_pending = load && (state_q != S_IDLE) && !(latch_end && !pend_vld_q);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    half_d     = half_q;
    shreg_d    = shreg_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    sdi_d      = sdi_q;
    sck_d      = sck_q;
    cs_n_d     = cs_n_q;
    ld_n_d     = ld_n_q;
    busy_d     = busy_q;
    ovr_d      = 1'b0;

    if (state_q != S_IDLE) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end

    case (state_q)
      S_SHIFT: begin
        if (tick) begin
          if (half_q == 5'd31) begin
            state_d = S_CSUP;
            cs_n_d  = 1'b1;
            sck_d   = 1'b0;
            sdi_d   = 1'b0;
          end else begin
            half_d = half_q + 5'd1;
            sck_d  = ~half_q[0];
            // Next half-period is even: SCK falls, present the next bit.
            if (half_q[0]) begin
              sdi_d   = shreg_q[14];
              shreg_d = {shreg_q[14:0], 1'b0};
            end
          end
        end
      end
      S_CSUP: begin
        if (tick) begin
          state_d = S_LATCH;
          ld_n_d  = 1'b0;
        end
      end
      S_LATCH: begin
        if (tick) begin
          state_d = S_IDLE;
          ld_n_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: ;
    endcase

    if (start) begin
      state_d = S_SHIFT;
      div_d   = '0;
      half_d  = '0;
      shreg_d = start_frame;
      sdi_d   = start_frame[15];
      sck_d   = 1'b0;
      cs_n_d  = 1'b0;
      busy_d  = 1'b1;
    end

    if (latch_end && pend_vld_q) begin
      pend_vld_d = 1'b0;
    end

    if (to_pending) begin
      pend_d     = data_in;
      pend_vld_d = 1'b1;
      ovr_d      = pend_vld_q && !latch_end;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      half_q     <= '0;
      shreg_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      sdi_q      <= 1'b0;
      sck_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      ld_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      half_q     <= half_d;
      shreg_q    <= shreg_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      sdi_q      <= sdi_d;
      sck_q      <= sck_d;
      cs_n_q     <= cs_n_d;
      ld_n_q     <= ld_n_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
    end
  end

  assign busy     = busy_q;
  assign overrun  = ovr_q;
  assign dac_sdi  = sdi_q;
  assign dac_sck  = sck_q;
  assign dac_cs_n = cs_n_q;
  assign dac_ld_n = ld_n_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: table vectors, randomized load schedules against an
// event-level model, and hand sequences for buffering, overrun, reset, CLK_DIV=1.
module tb_dac_spi_tx;

  localparam int CD = 2;

  typedef struct { logic [15:0] word; int bits; int start; int len; } frame_t;
  typedef struct { int start; int len; } span_t;
  typedef struct { logic [15:0] word; int start; } eframe_t;
  typedef struct { logic [9:0] din; logic [15:0] frame; } vec_t;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic [9:0] din0 = '0, din1 = '0;
  logic       ld0 = 1'b0, ld1 = 1'b0;
  logic       busy_w [2];
  logic       ovr_w  [2];
  logic       sdi_w  [2];
  logic       sck_w  [2];
  logic       csn_w  [2];
  logic       ldn_w  [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  dac_spi_tx #(.CLK_DIV(CD)) u_dut0 (
    .sysclk(sysclk), .rst_n(rst_n), .data_in(din0), .load(ld0),
    .busy(busy_w[0]), .overrun(ovr_w[0]), .dac_sdi(sdi_w[0]),
    .dac_sck(sck_w[0]), .dac_cs_n(csn_w[0]), .dac_ld_n(ldn_w[0])
  );

  dac_spi_tx #(.CLK_DIV(1)) u_dut1 (
    .sysclk(sysclk), .rst_n(rst_n), .data_in(din1), .load(ld1),
    .busy(busy_w[1]), .overrun(ovr_w[1]), .dac_sdi(sdi_w[1]),
    .dac_sck(sck_w[1]), .dac_cs_n(csn_w[1]), .dac_ld_n(ldn_w[1])
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observed activity on instance 0, timestamped with the cycle count.
  frame_t fq[$];
  span_t  lq[$];
  span_t  bq[$];
  int     oq[$];

  logic        p_csn, p_sck, p_ldn, p_busy;
  logic [15:0] m_word;
  int          m_bits, m_start, l_start, b_start;

  initial begin
    p_csn = 1'b1; p_sck = 1'b0; p_ldn = 1'b1; p_busy = 1'b0;
    m_word = '0; m_bits = 0; m_start = 0; l_start = 0; b_start = 0;
    forever begin
      @(negedge sysclk);
      if (!csn_w[0] && p_csn) begin m_start = cyc; m_bits = 0; m_word = '0; end
      if (!csn_w[0] && sck_w[0] && !p_sck) begin
        m_word = {m_word[14:0], sdi_w[0]};
        m_bits++;
      end
      if (csn_w[0] && !p_csn) fq.push_back('{m_word, m_bits, m_start, cyc - m_start});
      if (!ldn_w[0] && p_ldn) l_start = cyc;
      if (ldn_w[0] && !p_ldn) lq.push_back('{l_start, cyc - l_start});
      if (busy_w[0] && !p_busy) b_start = cyc;
      if (!busy_w[0] && p_busy) bq.push_back('{b_start, cyc - b_start});
      if (ovr_w[0]) oq.push_back(cyc);
      p_csn = csn_w[0]; p_sck = sck_w[0]; p_ldn = ldn_w[0]; p_busy = busy_w[0];
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] frame_of(input logic [9:0] d);
    return {1'b0, 1'b0, 1'b1, 1'b1, d, 2'b00};
  endfunction

  // Load schedule: absolute cycle of each load strobe and its sample.
  int         lt   [16];
  logic [9:0] ldat [16];
  eframe_t    ef[$];
  int         eo[$];

  // Event-level reference: a frame occupies 34*CD cycles; loads while busy
  // land in a one-deep buffer (newest wins) that starts the next frame.
  task automatic model(input int n);
    bit         have = 0;
    bit         pv   = 0;
    int         fend = 0;
    logic [9:0] pd   = '0;
    ef.delete();
    eo.delete();
    for (int i = 0; i < n; i++) begin
      int t;
      t = lt[i];
      while (have && fend <= t) begin
        if (pv) begin ef.push_back('{frame_of(pd), fend}); fend += 34 * CD; pv = 0; end
        else have = 0;
      end
      if (!have) begin
        have = 1;
        ef.push_back('{frame_of(ldat[i]), t});
        fend = t + 34 * CD;
      end else begin
        if (pv) eo.push_back(t);
        pv = 1;
        pd = ldat[i];
      end
    end
    while (have) begin
      if (pv) begin ef.push_back('{frame_of(pd), fend}); fend += 34 * CD; pv = 0; end
      else have = 0;
    end
  endtask

  task automatic drive(input int n);
    int idx = 0;
    int guard = 0;
    while (idx < n && guard < 20000) begin
      @(negedge sysclk);
      guard++;
      if (cyc + 1 == lt[idx]) begin ld0 = 1'b1; din0 = ldat[idx]; idx++; end
      else ld0 = 1'b0;
    end
    @(negedge sysclk);
    ld0 = 1'b0;
    if (idx != n) check("drive_schedule", idx, n);
  endtask

  task automatic run_sched(input int n);
    int k;
    int tgt;
    model(n);
    fq.delete(); lq.delete(); bq.delete(); oq.delete();
    drive(n);
    tgt = lt[n-1] + 160;
    while (cyc < tgt) @(negedge sysclk);
    check("frame_count", fq.size(), ef.size());
    k = (fq.size() < ef.size()) ? fq.size() : ef.size();
    for (int i = 0; i < k; i++) begin
      check($sformatf("frame_word[%0d]", i), fq[i].word, ef[i].word);
      check($sformatf("frame_start[%0d]", i), fq[i].start, ef[i].start);
      check($sformatf("frame_bits[%0d]", i), fq[i].bits, 16);
      check($sformatf("cs_low_cycles[%0d]", i), fq[i].len, 32 * CD);
    end
    check("ld_count", lq.size(), ef.size());
    k = (lq.size() < ef.size()) ? lq.size() : ef.size();
    for (int i = 0; i < k; i++) begin
      check($sformatf("ld_start[%0d]", i), lq[i].start, ef[i].start + 33 * CD);
      check($sformatf("ld_low_cycles[%0d]", i), lq[i].len, CD);
    end
    check("overrun_count", oq.size(), eo.size());
    k = (oq.size() < eo.size()) ? oq.size() : eo.size();
    for (int i = 0; i < k; i++) check($sformatf("overrun_cycle[%0d]", i), oq[i], eo[i]);
  endtask

  vec_t vecs [6];

  initial begin
    int t0;
    int sckbad;
    int csbad;
    logic [15:0] w;

    vecs[0] = '{10'h2A5, 16'h3A94};
    vecs[1] = '{10'h000, 16'h3000};
    vecs[2] = '{10'h3FF, 16'h3FFC};
    vecs[3] = '{10'h200, 16'h3800};
    vecs[4] = '{10'h155, 16'h3554};
    vecs[5] = '{10'h001, 16'h3004};

    repeat (3) @(negedge sysclk);
    check("rst_cs_n", csn_w[0], 1);
    check("rst_ld_n", ldn_w[0], 1);
    check("rst_sck", sck_w[0], 0);
    check("rst_sdi", sdi_w[0], 0);
    check("rst_busy", busy_w[0], 0);
    check("rst_overrun", ovr_w[0], 0);
    rst_n = 1'b1;
    repeat (3) @(negedge sysclk);

    // Single frames from IDLE.
    foreach (vecs[v]) begin
      lt[0] = cyc + 3; ldat[0] = vecs[v].din; t0 = lt[0];
      run_sched(1);
      if (fq.size() == 1) check($sformatf("vec%0d_frame", v), fq[0].word, vecs[v].frame);
      else check($sformatf("vec%0d_frames", v), fq.size(), 1);
      if (bq.size() == 1) begin
        check($sformatf("vec%0d_busy_rise", v), bq[0].start, t0);
        check($sformatf("vec%0d_busy_len", v), bq[0].len, 68);
      end else check($sformatf("vec%0d_busy_spans", v), bq.size(), 1);
      check($sformatf("vec%0d_sck_idle", v), sck_w[0], 0);
    end

    // Buffered load: back-to-back frames, no overrun.
    lt[0] = cyc + 3; lt[1] = lt[0] + 10; ldat[0] = 10'h200; ldat[1] = 10'h155; t0 = lt[0];
    run_sched(2);
    check("buf_frames", fq.size(), 2);
    if (fq.size() == 2) begin
      check("buf_second_start", fq[1].start, t0 + 68);
      check("buf_second_word", fq[1].word, 16'h3554);
    end
    check("buf_busy_spans", bq.size(), 1);
    if (bq.size() == 1) check("buf_busy_len", bq[0].len, 136);
    check("buf_no_overrun", oq.size(), 0);

    // Overrun: middle sample discarded.
    lt[0] = cyc + 3; lt[1] = lt[0] + 5; lt[2] = lt[0] + 9;
    ldat[0] = 10'h100; ldat[1] = 10'h0AA; ldat[2] = 10'h3C0; t0 = lt[0];
    run_sched(3);
    check("ovr_pulses", oq.size(), 1);
    if (oq.size() == 1) check("ovr_cycle", oq[0], t0 + 9);
    check("ovr_frames", fq.size(), 2);
    if (fq.size() == 2) check("ovr_second_word", fq[1].word, 16'h3F00);

    // Randomized schedules against the model.
    for (int r = 0; r < 3; r++) begin
      lt[0] = cyc + 3;
      ldat[0] = 10'($urandom_range(0, 1023));
      for (int i = 1; i < 14; i++) begin
        lt[i]   = lt[i-1] + int'($urandom_range(1, 75));
        ldat[i] = 10'($urandom_range(0, 1023));
      end
      run_sched(14);
    end

    // Reset mid-frame with a pending sample queued.
    fq.delete(); lq.delete(); bq.delete(); oq.delete();
    lt[0] = cyc + 3; ldat[0] = 10'h2A5; t0 = lt[0];
    drive(1);
    while (cyc < t0 + 4) @(negedge sysclk);
    ld0 = 1'b1; din0 = 10'h155;
    @(negedge sysclk);
    ld0 = 1'b0;
    while (cyc < t0 + 19) @(negedge sysclk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cs_n", csn_w[0], 1);
    check("midrst_ld_n", ldn_w[0], 1);
    check("midrst_sck", sck_w[0], 0);
    check("midrst_sdi", sdi_w[0], 0);
    check("midrst_busy", busy_w[0], 0);
    check("midrst_overrun", ovr_w[0], 0);
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    repeat (200) @(negedge sysclk);
    check("midrst_no_ldac", lq.size(), 0);
    check("midrst_aborted_only", fq.size(), 1);
    if (fq.size() == 1) check("midrst_partial", (fq[0].bits < 16) ? 1 : 0, 1);
    check("midrst_idle", busy_w[0], 0);
    lt[0] = cyc + 3; ldat[0] = 10'h001;
    run_sched(1);
    if (fq.size() == 1) check("midrst_after_frame", fq[0].word, 16'h3004);

    // CLK_DIV = 1 instance, sampled cycle by cycle.
    @(negedge sysclk);
    ld1 = 1'b1; din1 = 10'h3FF; t0 = cyc + 1;
    @(negedge sysclk);
    ld1 = 1'b0;
    sckbad = 0; csbad = 0; w = '0;
    for (int c = 0; c <= 34; c++) begin
      if (c < 32) begin
        if (sck_w[1] !== 1'(c % 2)) sckbad++;
        if (csn_w[1] !== 1'b0) csbad++;
        if (c % 2 == 1) w = {w[14:0], sdi_w[1]};
      end
      if (c == 32) check("div1_cs_up", csn_w[1], 1);
      if (c == 33) check("div1_ld_low", ldn_w[1], 0);
      if (c == 34) begin
        check("div1_ld_high", ldn_w[1], 1);
        check("div1_busy_done", busy_w[1], 0);
      end
      @(negedge sysclk);
    end
    check("div1_sck_toggle_errors", sckbad, 0);
    check("div1_cs_low_errors", csbad, 0);
    check("div1_frame", w, 16'h3FFC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serial transmitter that drives the MCP4911 10-bit SPI DAC from the parallel 10-bit offset-binary sample the audio processor produces each sample period. It sits between the processor's registered DAC-side output and the board's DAC pins. It packs each sample into a 16-bit MCP4911 write frame, shifts it out MSB-first, then pulses LDAC to update the analogue output. A one-deep pending buffer lets the processor issue a new sample while a frame is in flight.

## Interface
- CLK_DIV, 25, sysclk cycles per SCK half-period; integer ≥ 1 (50 MHz sysclk → 1 MHz SCK)
- sysclk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- data_in  in  10  DAC code, offset binary (0x200 = mid-scale)
- load  in  1  one-cycle strobe: data_in valid this cycle
- busy  out  1  high while a frame, CS-high gap or LDAC pulse is in progress
- overrun  out  1  one-cycle pulse when a pending sample is overwritten
- dac_sdi  out  1  serial data to DAC
- dac_sck  out  1  serial clock; idles low
- dac_cs_n  out  1  chip select, active-low
- dac_ld_n  out  1  LDAC, active-low latch strobe

## Operation
- Frame, MSB first: {1'b0 (write), 1'b0 (BUF off), 1'b1 (GA_n, 1x gain), 1'b1 (SHDN_n, active), data[9:0], 2'b00}.
- States:
  - IDLE → SHIFT on load.
  - SHIFT covers 32 half-periods; → CSUP after the 32nd.
  - CSUP covers one half-period with cs_n high; → LATCH.
  - LATCH covers one half-period with ld_n low; → IDLE, or → SHIFT if pending valid.
- Half-period counter runs 0..CLK_DIV-1. Half-period index h runs 0..31 in SHIFT.
- In SHIFT, dac_sck = h[0]. dac_sdi = frame[15 - h/2], updated only at even h (SCK falling or frame start). The DAC samples on SCK rising.
- load in IDLE: capture data_in into the shift register this edge. A load in the same cycle that LATCH ends with no pending behaves as in IDLE.
- load while busy: data_in goes into the pending register and pending_valid is set. If pending_valid was already set, the new value overwrites it (newest wins) and overrun pulses for one cycle.
- At the end of LATCH with pending_valid: load the pending value, clear pending_valid and enter SHIFT on the same edge. busy stays high. If a load arrives on that same edge, it becomes the new pending value and does not overrun.
- Reset values (async, while rst_n low):
  - dac_cs_n = 1, dac_ld_n = 1
  - dac_sck = 0, dac_sdi = 0
  - busy = 0, overrun = 0
  - pending_valid = 0, state IDLE
- rst_n asserted mid-frame aborts the frame at once. There is no LDAC pulse and no resume after release.
- All outputs are registered, so there are no glitches on DAC pins.

## Timing
- T0 is the edge where load is sampled in IDLE. After T0: cs_n = 0, sck = 0, sdi = frame[15], busy = 1.
- Bit k (k = 0..15) is presented at T0 + 2k·CLK_DIV. SCK rises at T0 + (2k+1)·CLK_DIV and falls at T0 + (2k+2)·CLK_DIV.
- T0 + 32·CLK_DIV: cs_n = 1, sck = 0, sdi = 0 (CSUP).
- T0 + 33·CLK_DIV: ld_n = 0 (LATCH).
- T0 + 34·CLK_DIV: ld_n = 1, and either busy = 0 or the next frame starts (cs_n = 0).
- Frame period is 34·CLK_DIV cycles. Latency from load to LDAC falling is 33·CLK_DIV cycles.
- SDI is stable for the full CLK_DIV cycles before and after each SCK rising edge.
- CS_n stays low for exactly 32·CLK_DIV cycles. LDAC stays low for exactly CLK_DIV cycles.

## Test plan
- CLK_DIV = 2, load with data_in = 0x2A5 in IDLE:
  - sampling sdi on 16 SCK rises gives 0x3A94
  - cs_n low for 64 cycles
  - ld_n low for cycles 66–67 after T0
  - busy low at T0 + 68
- Boundary codes, CLK_DIV = 2: data_in = 0x000 → frame 0x3000; data_in = 0x3FF → frame 0x3FFC; sck idles low between frames.
- Buffered load, CLK_DIV = 2: 0x200 at T0, then 0x155 at T0 + 10.
  - second frame 0x3554 begins at T0 + 68 with no idle gap
  - busy continuously high for 136 cycles
  - overrun never pulses
- Overrun, CLK_DIV = 2: loads of 0x100, 0x0AA, 0x3C0 at T0, T0 + 5, T0 + 9.
  - overrun pulses once, the cycle after T0 + 9
  - second frame is 0x3F00 (0x0AA discarded)
- Reset mid-frame: rst_n low at T0 + 20 (CLK_DIV = 2).
  - outputs go to reset values immediately, with no LDAC pulse
  - pending_valid cleared
  - after release, a load of 0x001 yields frame 0x3004
- CLK_DIV = 1, data_in = 0x3FF: sck toggles every cycle, 34-cycle frame, sdi stream 0x3FFC.
